peripheral_io_arbiter: RTL
==========================

# peripheral_io_arbiter

Two-requester arbiter and transaction sequencer that shares the single CPU-side IO request port of the peripheral interface controller between two masters (e.g. CPU data port and DMA engine). It grants round-robin, issues exactly one outstanding transaction at a time, routes the returning read data or write acknowledge to the owning master, and recovers from a lost response with a timeout.

## Interface
- P_TIMEOUT, 256: WAIT-state cycle limit before a synthetic error response (2..65535).
- iCLOCK  in  1  single clock, all logic on rising edge.
- iRESET_SYNC  in  1  reset, synchronous, active-high.
- iM0_REQ / iM1_REQ  in  1  request from master n; held with payload until accepted.
- oM0_BUSY / oM1_BUSY  out  1  request not accepted this cycle.
- iMn_ORDER  in  2  access size, passed through unchanged.
- iMn_RW  in  1  0=write, 1=read (CPU-side convention).
- iMn_ADDR, iMn_DATA  in  32 each  address, write data.
- oMn_VALID  out  1  response to master n (read data or write ack).
- iMn_BUSY  in  1  master n cannot take the response.
- oMn_DATA  out  32  response data.
- oIO_REQ  out  1  request to controller.
- iIO_BUSY  in  1  controller stall.
- oIO_ORDER 2, oIO_RW 1, oIO_ADDR 32, oIO_DATA 32  out  latched payload.
- iIO_VALID  in  1  controller response.
- oIO_BUSY  out  1  response backpressure to controller.
- iIO_DATA  in  32  controller response data.
- oOWNER  out  1  master owning the current transaction.
- oTIMEOUT  out  1  one-cycle pulse when a timeout response is generated.

## Operation
- States: IDLE, ISSUE, WAIT, RETURN. Registers: state, owner, last_grant, payload latch, response data, counter (clog2(P_TIMEOUT) bits).
- IDLE: winner combinational. Only one REQ -> that master. Both -> master != last_grant. Winner's oMn_BUSY=0, loser's=1. Accept (REQ && !oMn_BUSY): latch ORDER/RW/ADDR/DATA, owner<=winner, last_grant<=winner, -> ISSUE.
- Outside IDLE both oMn_BUSY=1.
- ISSUE: oIO_REQ=1, payload = latch. If !iIO_BUSY: request taken, clear counter, -> WAIT. If iIO_BUSY: hold REQ and payload stable.
- WAIT: oIO_BUSY=0. iIO_VALID -> capture iIO_DATA, -> RETURN. Otherwise counter++; when counter==P_TIMEOUT-1 without VALID: response data<=32'hFFFF_FFFF, oTIMEOUT pulse, -> RETURN.
- RETURN: oIO_BUSY=1; oM[owner]_VALID=1, oM[owner]_DATA=captured data, held while iM[owner]_BUSY=1. When !iM[owner]_BUSY: -> IDLE. Non-owner VALID stays 0.
- oIO_BUSY=0 in IDLE/ISSUE/WAIT. iIO_VALID outside WAIT (late response after timeout) is discarded, never routed.
- Simultaneous iIO_VALID and timeout threshold in same cycle: VALID wins, no oTIMEOUT.
- iRESET_SYNC has priority over all events, including mid-transaction: state<=IDLE, last_grant<=1 (M0 wins first tie), counter, latch and response data <=0. In-flight transaction is abandoned with no response.

## Timing
- Reset values (cycle after iRESET_SYNC): oIO_REQ=0, oIO_ORDER/RW/ADDR/DATA=0, oIO_BUSY=0, oMn_VALID=0, oMn_DATA=0, oOWNER=0, oTIMEOUT=0; oMn_BUSY per IDLE arbitration (not accepted while iRESET_SYNC=1).
- Accept at cycle T -> oIO_REQ=1 at T+1; with iIO_BUSY=0 the request is one cycle wide, WAIT from T+2.
- iIO_VALID at cycle V in WAIT -> oMn_VALID at V+1.
- Timeout: WAIT entered at W, no VALID -> oTIMEOUT and RETURN at W+P_TIMEOUT.
- RETURN exits on the first cycle owner BUSY=0; next accept earliest the following cycle. Min throughput: one transaction per 4 cycles + controller latency.

## Test plan
- Single read: M0 REQ RW=1 ADDR=0x100 -> oIO_REQ 1 cycle later with ADDR 0x100; iIO_VALID DATA=0xDEADBEEF -> oM0_VALID next cycle, data 0xDEADBEEF; M1 sees nothing.
- Tie round-robin: M0, M1 request simultaneously from reset, held -> grant order M0, M1, M0, M1; loser BUSY=1 throughout.
- Backpressure: iIO_BUSY=1 for 3 cycles in ISSUE -> payload stable, single accepted request; iM1_BUSY=1 for 2 cycles in RETURN -> oM1_VALID/DATA held 3 cycles, exactly one transfer.
- Timeout: P_TIMEOUT=8, no iIO_VALID -> 8 cycles after WAIT entry oTIMEOUT pulse, owner gets 0xFFFFFFFF; late iIO_VALID then ignored.
- Reset mid-WAIT: iRESET_SYNC=1 one cycle -> all outputs at reset values, next tie grants M0, no stale response delivered.

Source files
------------

// File: rtl/peripheral_io_arbiter.sv
// Shares one IO request port between two masters: round-robin grant, one
// outstanding transaction, response routed to the owner, timeout recovery.
module peripheral_io_arbiter #(
    parameter int P_TIMEOUT = 256
) (
    input  logic        iCLOCK,
    input  logic        iRESET_SYNC,
    input  logic        iM0_REQ,
    output logic        oM0_BUSY,
    input  logic [1:0]  iM0_ORDER,
    input  logic        iM0_RW,
    input  logic [31:0] iM0_ADDR,
    input  logic [31:0] iM0_DATA,
    output logic        oM0_VALID,
    input  logic        iM0_BUSY,
    output logic [31:0] oM0_DATA,
    input  logic        iM1_REQ,
    output logic        oM1_BUSY,
    input  logic [1:0]  iM1_ORDER,
    input  logic        iM1_RW,
    input  logic [31:0] iM1_ADDR,
    input  logic [31:0] iM1_DATA,
    output logic        oM1_VALID,
    input  logic        iM1_BUSY,
    output logic [31:0] oM1_DATA,
    output logic        oIO_REQ,
    input  logic        iIO_BUSY,
    output logic [1:0]  oIO_ORDER,
    output logic        oIO_RW,
    output logic [31:0] oIO_ADDR,
    output logic [31:0] oIO_DATA,
    input  logic        iIO_VALID,
    output logic        oIO_BUSY,
    input  logic [31:0] iIO_DATA,
    output logic        oOWNER,
    output logic        oTIMEOUT,
    output logic [1:0]  oDEBUG_STATE
);
    localparam int CW = $clog2(P_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(P_TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RETURN} state_t;

    // Handshake: a master transfer happens on REQ && !BUSY, the controller takes
    // a request on oIO_REQ && !iIO_BUSY, and a response moves on VALID && !BUSY.
    state_t        state, state_nx;
    logic          owner, last_grant;
    logic [1:0]    lat_order;
    logic          lat_rw;
    logic [31:0]   lat_addr, lat_data, resp_data;
    logic [CW-1:0] count;
    logic          timeout_q;

    logic winner, accept, owner_busy, timeout_hit;

    // On a tie the master that did not win last time gets the grant.
    assign winner      = (iM0_REQ && iM1_REQ) ? ~last_grant : iM1_REQ;
    assign accept      = (state == S_IDLE) && (winner ? iM1_REQ : iM0_REQ);
    assign owner_busy  = owner ? iM1_BUSY : iM0_BUSY;
    assign timeout_hit = (state == S_WAIT) && !iIO_VALID && (count == CNT_LAST);

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) state <= S_IDLE;
        else             state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        oM0_BUSY  = 1'b1;
        oM1_BUSY  = 1'b1;
        oIO_REQ   = 1'b0;
        oIO_BUSY  = 1'b0;
        oM0_VALID = 1'b0;
        oM1_VALID = 1'b0;
        oM0_DATA  = 32'h0;
        oM1_DATA  = 32'h0;
        case (state)
            S_IDLE: begin
                oM0_BUSY = winner;
                oM1_BUSY = ~winner;
                if (accept) state_nx = S_ISSUE;
            end
            S_ISSUE: begin
                oIO_REQ = 1'b1;
                if (!iIO_BUSY) state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (iIO_VALID || timeout_hit) state_nx = S_RETURN;
            end
            S_RETURN: begin
                oIO_BUSY = 1'b1;
                if (owner) begin
                    oM1_VALID = 1'b1;
                    oM1_DATA  = resp_data;
                end else begin
                    oM0_VALID = 1'b1;
                    oM0_DATA  = resp_data;
                end
                if (!owner_busy) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            owner      <= 1'b0;
            last_grant <= 1'b1;
            lat_order  <= 2'b0;
            lat_rw     <= 1'b0;
            lat_addr   <= 32'h0;
            lat_data   <= 32'h0;
            resp_data  <= 32'h0;
            count      <= '0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= timeout_hit;
            if (accept) begin
                owner      <= winner;
                last_grant <= winner;
                lat_order  <= winner ? iM1_ORDER : iM0_ORDER;
                lat_rw     <= winner ? iM1_RW    : iM0_RW;
                lat_addr   <= winner ? iM1_ADDR  : iM0_ADDR;
                lat_data   <= winner ? iM1_DATA  : iM0_DATA;
            end
            if (state == S_ISSUE && !iIO_BUSY)
                count <= '0;
            else if (state == S_WAIT && !iIO_VALID && !timeout_hit)
                count <= count + CW'(1);
            // A response landing on the timeout cycle still wins over the error value.
            if (state == S_WAIT) begin
                if (iIO_VALID)        resp_data <= iIO_DATA;
                else if (timeout_hit) resp_data <= 32'hFFFF_FFFF;
            end
        end
    end

    assign oIO_ORDER    = lat_order;
    assign oIO_RW       = lat_rw;
    assign oIO_ADDR     = lat_addr;
    assign oIO_DATA     = lat_data;
    assign oOWNER       = owner;
    assign oTIMEOUT     = timeout_q;
    assign oDEBUG_STATE = state;

endmodule
